// File: rtl/sccb_pkg.sv
// -----------------------------------------------------------------------------
// sccb_pkg
// Shared types and constants for the SCCB/I2C register target.
//   sccb_state_t : FSM state encoding of the target protocol engine
//   COND_*       : bus-condition codes reported by sccb_line_sync
//   BYTE_BITS    : bits per SCCB byte (MSB first)
//   ack_next()   : state that follows an ACK slot the target drives
// -----------------------------------------------------------------------------
package sccb_pkg;

    localparam int BYTE_BITS = 8;

    // Bus condition seen on the synchronized lines in the current cycle.
    localparam logic [1:0] COND_NONE  = 2'b00;
    localparam logic [1:0] COND_STOP  = 2'b01;
    localparam logic [1:0] COND_START = 2'b10;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DEVA     = 4'd1,
        ACK_DEVA = 4'd2,
        ADDR_HI  = 4'd3,
        ACK_HI   = 4'd4,
        ADDR_LO  = 4'd5,
        ACK_LO   = 4'd6,
        WDATA    = 4'd7,
        ACK_W    = 4'd8,
        RDATA    = 4'd9,
        MACK     = 4'd10,
        IGNORE   = 4'd11
    } sccb_state_t;

    // Where the engine goes once the target has finished driving an ACK.
    // rw is the R/W bit of the device-address byte (only used after ACK_DEVA).
    function automatic sccb_state_t ack_next(input sccb_state_t s, input logic rw);
        case (s)
            ACK_DEVA: ack_next = rw ? RDATA : ADDR_HI;
            ACK_HI:   ack_next = ADDR_LO;
            default:  ack_next = WDATA;
        endcase
    endfunction

endpackage

// File: rtl/sccb_if.sv
// -----------------------------------------------------------------------------
// sccb_if
// Register-write report bus of the SCCB target, plus FSM state for debug.
//   wr_valid  : one-cycle strobe per data byte written into the register file
//   wr_addr   : 16-bit register address of that byte
//   wr_data   : the data byte
//   busy      : high from START until STOP
//   dbg_state : current protocol FSM state
// Handshake: wr_valid is a pure strobe with no ready. The consumer must take
// wr_addr/wr_data in the cycle wr_valid is high; the target cannot stall
// because it never stretches SCL. wr_addr/wr_data hold until the next write.
// Modports: slave = the target (drives everything), master = the consumer.
// -----------------------------------------------------------------------------
interface sccb_if;
    import sccb_pkg::*;

    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    sccb_state_t dbg_state;

    modport slave  (output wr_valid, wr_addr, wr_data, busy, dbg_state);
    modport master (input  wr_valid, wr_addr, wr_data, busy, dbg_state);

endinterface

// File: rtl/sccb_line_sync.sv
// -----------------------------------------------------------------------------
// sccb_line_sync
// Synchronizes SCL and SDA into clk, then compares against a one-cycle delayed
// copy to find SCL edges and START/STOP conditions.
//   clk, rst   : system clock, async active-high reset (flops preset to 1 = idle bus)
//   scl_in     : raw SCL pin
//   sda_in     : raw SDA pin (resolved open-drain value)
//   sda        : synchronized SDA level
//   scl_rise   : synchronized SCL went 0->1 this cycle
//   scl_fall   : synchronized SCL went 1->0 this cycle
//   cond       : COND_START / COND_STOP / COND_NONE
// Both lines share the same synchronizer depth, so their relative timing is
// preserved and a data change during SCL low never looks like START/STOP.
// -----------------------------------------------------------------------------
module sccb_line_sync
    import sccb_pkg::*;
#(
    parameter int SYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic [1:0] cond
);

    logic [SYNC_LEN-1:0] scl_sync;
    logic [SYNC_LEN-1:0] sda_sync;
    logic                scl_d;
    logic                sda_d;
    logic                scl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_LEN-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_LEN-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_LEN-1];
            sda_d    <= sda_sync[SYNC_LEN-1];
        end
    end

    assign scl      = scl_sync[SYNC_LEN-1];
    assign sda      = sda_sync[SYNC_LEN-1];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;

    // SCL must be high in both samples so an SCL edge coinciding with an SDA
    // edge is not mistaken for a bus condition.
    always_comb begin
        cond = COND_NONE;
        if (scl && scl_d && sda_d && !sda) begin
            cond = COND_START;
        end else if (scl && scl_d && !sda_d && sda) begin
            cond = COND_STOP;
        end
    end

endmodule

// File: rtl/sccb_target.sv
// -----------------------------------------------------------------------------
// sccb_target
// SCCB/I2C target modelled on the OV5640 camera register interface:
// 7-bit device address, 16-bit register address, 8-bit data, small register
// file. Write: S,dev+W,regH,regL,data..,P. Read: S,dev+W,regH,regL,Sr,dev+R,data..,P.
// Parameters:
//   DEV_ADDR : 7-bit device address answered
//   IDX_BITS : register file holds 2**IDX_BITS bytes, indexed by reg_addr[IDX_BITS-1:0]
//   SYNC_LEN : synchronizer depth on SCL/SDA (>=2)
// Ports:
//   clk_in   : system clock, at least 20x the SCL rate
//   rst_in   : asynchronous active-high reset
//   scl_pin  : SCL input (never stretched)
//   sda_pin  : SDA open drain, pulled low when sda_oe, otherwise released
//   bus      : sccb_if.slave write-report bus (wr_valid/wr_addr/wr_data/busy/dbg_state)
// Build option:
//   SCCB_TARGET_AUTOINC_EN defined  -> reg_addr steps by one after each data
//                                      byte (read or write), wrapping at 16 bits.
//   SCCB_TARGET_AUTOINC_EN undefined -> reg_addr held for the whole transaction.
// The register file is not reset.
// -----------------------------------------------------------------------------
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         IDX_BITS = 8,
    parameter int         SYNC_LEN = 2
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  scl_pin,
    inout  wire   sda_pin,
    sccb_if.slave bus
);

`ifdef SCCB_TARGET_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    // Synchronized line events.
    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic [1:0] cond;

    sccb_line_sync #(
        .SYNC_LEN (SYNC_LEN)
    ) u_line_sync (
        .clk      (clk_in),
        .rst      (rst_in),
        .scl_in   (scl_pin),
        .sda_in   (sda_pin),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .cond     (cond)
    );

    // Registered state.
    sccb_state_t state,    state_nxt;
    logic        sda_oe,   sda_oe_nxt;
    logic [7:0]  shift,    shift_nxt;
    logic [2:0]  bit_cnt,  bit_cnt_nxt;
    logic [7:0]  addr_hi,  addr_hi_nxt;
    logic [15:0] reg_addr, reg_addr_nxt;
    logic        wr_valid, wr_valid_nxt;
    logic [15:0] wr_addr,  wr_addr_nxt;
    logic [7:0]  wr_data,  wr_data_nxt;
    logic        busy,     busy_nxt;

    // Register file.
    logic [7:0]  regfile [2**IDX_BITS];
    logic        rf_we;
    logic [7:0]  rf_rdata;
    logic [7:0]  rx_byte;

    assign rf_rdata = regfile[reg_addr[IDX_BITS-1:0]];

    // Byte as it will look once the current SDA sample is shifted in.
    assign rx_byte = {shift[BYTE_BITS-2:0], sda};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            sda_oe   <= 1'b0;
            shift    <= 8'h00;
            bit_cnt  <= 3'd0;
            addr_hi  <= 8'h00;
            reg_addr <= 16'h0000;
            wr_valid <= 1'b0;
            wr_addr  <= 16'h0000;
            wr_data  <= 8'h00;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            sda_oe   <= sda_oe_nxt;
            shift    <= shift_nxt;
            bit_cnt  <= bit_cnt_nxt;
            addr_hi  <= addr_hi_nxt;
            reg_addr <= reg_addr_nxt;
            wr_valid <= wr_valid_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
            busy     <= busy_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rf_we) begin
            regfile[reg_addr[IDX_BITS-1:0]] <= rx_byte;
        end
    end

    always_comb begin
        state_nxt    = state;
        sda_oe_nxt   = sda_oe;
        shift_nxt    = shift;
        bit_cnt_nxt  = bit_cnt;
        addr_hi_nxt  = addr_hi;
        reg_addr_nxt = reg_addr;
        wr_valid_nxt = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        busy_nxt     = busy;
        rf_we        = 1'b0;

        if (cond == COND_STOP) begin
            // Any partial byte is simply dropped.
            state_nxt   = IDLE;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
            bit_cnt_nxt = 3'd0;
        end else if (cond == COND_START) begin
            // Also covers repeated START; reg_addr is kept for a following read.
            state_nxt   = DEVA;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b1;
            bit_cnt_nxt = 3'd0;
        end else begin
            case (state)
                DEVA, ADDR_HI, ADDR_LO, WDATA: begin
                    if (scl_rise) begin
                        shift_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        // Count wraps to 0 on the 8th bit; the ACK slot is its own state.
                        if (bit_cnt == 3'd7) begin
                            if (state == DEVA) begin
                                state_nxt = (rx_byte[7:1] == DEV_ADDR) ? ACK_DEVA : IGNORE;
                            end else if (state == ADDR_HI) begin
                                addr_hi_nxt = rx_byte;
                                state_nxt   = ACK_HI;
                            end else if (state == ADDR_LO) begin
                                reg_addr_nxt = {addr_hi, rx_byte};
                                state_nxt    = ACK_LO;
                            end else begin
                                rf_we        = 1'b1;
                                wr_valid_nxt = 1'b1;
                                wr_addr_nxt  = reg_addr;
                                wr_data_nxt  = rx_byte;
                                if (AUTOINC) begin
                                    reg_addr_nxt = reg_addr + 16'd1;
                                end
                                state_nxt = ACK_W;
                            end
                        end
                    end
                end

                ACK_DEVA, ACK_HI, ACK_LO, ACK_W: begin
                    // First SCL fall (end of bit 8) pulls SDA low; the second
                    // (end of the ACK clock) releases it and moves on.
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = 1'b1;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = ack_next(state, shift[0]);
                            if (state == ACK_DEVA && shift[0]) begin
                                // Read: first data bit goes out on this same fall.
                                shift_nxt   = rf_rdata;
                                sda_oe_nxt  = ~rf_rdata[7];
                                bit_cnt_nxt = 3'd0;
                            end
                        end
                    end
                end

                RDATA: begin
                    if (scl_fall) begin
                        sda_oe_nxt = ~shift[7];
                    end
                    if (scl_rise) begin
                        shift_nxt   = {shift[BYTE_BITS-2:0], 1'b0};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nxt = MACK;
                            if (AUTOINC) begin
                                reg_addr_nxt = reg_addr + 16'd1;
                            end
                        end
                    end
                end

                MACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                    end
                    if (scl_rise) begin
                        if (!sda) begin
                            // Master ACK: preload the next byte; its MSB is
                            // driven on the following SCL fall in RDATA.
                            state_nxt   = RDATA;
                            shift_nxt   = rf_rdata;
                            bit_cnt_nxt = 3'd0;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                end

                default: begin
                    // IDLE and IGNORE wait for START/STOP only.
                end
            endcase
        end
    end

    assign sda_pin = sda_oe ? 1'b0 : 1'bz;

    assign bus.wr_valid  = wr_valid;
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    assign bus.busy      = busy;
    assign bus.dbg_state = state;

endmodule
